umi_merge: RTL and testbench
============================

UMI_MERGE -- requirements
Module: umi_merge

Interface
REQ-001 SHALL have parameter CW, default 32, UMI command width.
REQ-002 SHALL have parameter AW, default 64, address width.
REQ-003 SHALL have parameter IDW, default 128, input data width; IDW<=ODW, both powers of two, both multiples of 8.
REQ-004 SHALL have parameter ODW, default 512, output data width.
REQ-005 SHALL have parameter TIMEOUT, default 16, idle cycles before a partial accumulation is flushed.
REQ-006 SHALL have ports: clk input 1, the single clock; nreset input 1, asynchronous active-low reset.
REQ-007 SHALL have ports: umi_in_valid in 1; umi_in_cmd in CW; umi_in_dstaddr in AW; umi_in_srcaddr in AW; umi_in_data in IDW; umi_in_ready out 1.
REQ-008 SHALL have ports: umi_out_valid out 1; umi_out_cmd out CW; umi_out_dstaddr out AW; umi_out_srcaddr out AW; umi_out_data out ODW; umi_out_ready in 1.

Function
REQ-009 SHALL merge consecutive narrow UMI segments, as produced by the width-splitting FIFO, into one ODW-wide transaction; decode and encode through umi_unpack/umi_pack.
REQ-010 SHALL define beat bytes B=(cmd_len+1)<<cmd_size and accumulated byte count ACC, width clog2(ODW/8)+1.
REQ-011 SHALL implement states IDLE, ACCUM, SEND; reset state IDLE.
REQ-012 IDLE: umi_in_ready=1. On an accepted beat, SHALL load cmd, dstaddr, srcaddr and data (low B bytes) and set ACC=B. If eom=1 or ACC==ODW/8, go to SEND; otherwise go to ACCUM.
REQ-013 Compatible beat: all umi_unpack fields except cmd_len/cmd_eom equal the held ones, dstaddr==held dstaddr+ACC, srcaddr==held srcaddr+ACC, and ACC+B<=ODW/8.
REQ-014 ACCUM, compatible beat valid: umi_in_ready=1. SHALL place the beat's low B bytes at byte offset ACC, set ACC+=B, set len=(ACC>>size)-1 and eom=incoming eom. Go to SEND if eom=1 or ACC==ODW/8; else stay in ACCUM.
REQ-015 ACCUM, incompatible beat valid: umi_in_ready=0 combinationally, go to SEND with the held eom=0. The pending beat is accepted later from IDLE.
REQ-016 SEND: umi_out_valid=1 and outputs driven from held registers, stable until umi_out_ready; umi_in_ready=0; on umi_out_ready go to IDLE.
REQ-017 Output data bytes at or above ACC SHALL be zero; umi_out_dstaddr/srcaddr SHALL be the first segment's addresses.
REQ-018 Minimum latency: a beat accepted in cycle N with eom=1 SHALL appear with umi_out_valid in cycle N+1; throughput is at most one output per two cycles.
REQ-019 umi_in_ready SHALL NOT depend on umi_out_ready; umi_out_valid SHALL NOT depend on umi_in_valid.

Reset
REQ-020 nreset low SHALL asynchronously force: state IDLE; ACC, held cmd/addr/data and timeout counter to 0; umi_out_valid=0; umi_out_cmd/dstaddr/srcaddr/data=0; umi_in_ready=0 while nreset is low.
REQ-021 Reset during ACCUM or SEND SHALL discard the accumulation with no output.

Configuration
REQ-022 Macro UMI_MERGE_TIMEOUT_EN defined: an idle counter SHALL clear on each accepted beat, increment each ACCUM cycle with umi_in_valid=0, and on reaching TIMEOUT go to SEND with the held eom.
REQ-023 UMI_MERGE_TIMEOUT_EN undefined: no counter; ACCUM exits only per REQ-014/REQ-015.

Verification (IDW=128, ODW=512, size=0)
REQ-024 Four beats, len=15, dst 0x100/0x110/0x120/0x130, eom 0,0,0,1 -> one output: len=63, eom=1, dst 0x100, data = four segments concatenated in order.
REQ-025 Single beat, len=7, eom=1, dst 0x40 -> output next cycle: len=7, eom=1, data bytes 8..63 zero.
REQ-026 Beat dst 0x100 eom=0, then beat dst 0x200 -> umi_in_ready=0 on the second beat; first output len=15 eom=0; second beat accepted after the flush.
REQ-027 With UMI_MERGE_TIMEOUT_EN: one beat eom=0, then umi_in_valid=0 -> umi_out_valid rises 17 cycles after acceptance; without the macro, no output.
REQ-028 Hold umi_out_ready=0 for 5 cycles in SEND -> outputs stable and umi_in_ready=0 throughout; then a handshake returns to IDLE.
REQ-029 nreset asserted after two merged beats -> umi_out_valid=0 immediately, and no output after release.

Source files
------------

// File: rtl/umi_merge.sv
// umi_merge: merges consecutive narrow UMI segments into one ODW-wide transaction.
// Optional idle-flush timer enabled by defining UMI_MERGE_TIMEOUT_EN.
module umi_merge #(
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int IDW     = 128,
  parameter int ODW     = 512,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           umi_in_valid,
  input  logic [CW-1:0]  umi_in_cmd,
  input  logic [AW-1:0]  umi_in_dstaddr,
  input  logic [AW-1:0]  umi_in_srcaddr,
  input  logic [IDW-1:0] umi_in_data,
  output logic           umi_in_ready,
  output logic           umi_out_valid,
  output logic [CW-1:0]  umi_out_cmd,
  output logic [AW-1:0]  umi_out_dstaddr,
  output logic [AW-1:0]  umi_out_srcaddr,
  output logic [ODW-1:0] umi_out_data,
  input  logic           umi_out_ready
);
  localparam int IB = IDW / 8;
  localparam int OB = ODW / 8;
  localparam int ACW = $clog2(OB) + 1;
  // every field except len and eom must match for segments to merge
  localparam logic [CW-1:0] KEEP = ~CW'(32'h0040_FF00);
  typedef enum logic [1:0] {IDLE, ACCUM, SEND} state_t;
  state_t state, state_n;
  logic [ACW-1:0] acc, b, nacc;
  logic [CW-1:0] cmd, cmd_m;
  logic [AW-1:0] dst, src;
  logic [ODW-1:0] data, data_m;
  logic [IDW-1:0] din;
  logic [15:0] bw;
  logic in_eom, compat, rdy, load, merge;
`ifdef UMI_MERGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`endif
  assign in_eom = umi_in_cmd[22];
  always_comb begin
    bw = (16'(umi_in_cmd[15:8]) + 16'd1) << umi_in_cmd[7:5];
    b = (bw > 16'(IB)) ? ACW'(IB) : ACW'(bw);
    nacc = acc + b;
    for (int i = 0; i < IB; i++) din[8*i +: 8] = (ACW'(i) < b) ? umi_in_data[8*i +: 8] : 8'h00;
    cmd_m = cmd;
    cmd_m[15:8] = 8'((nacc >> umi_in_cmd[7:5]) - ACW'(1));
    cmd_m[22] = in_eom;
    data_m = data | (ODW'(din) << {acc, 3'b000});
    compat = (((umi_in_cmd ^ cmd) & KEEP) == '0) &&
             (umi_in_dstaddr == dst + AW'(acc)) &&
             (umi_in_srcaddr == src + AW'(acc)) &&
             (nacc <= ACW'(OB));
  end
  always_comb begin
    state_n = state;
    rdy = 1'b0;
    load = 1'b0;
    merge = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        load = umi_in_valid;
        if (umi_in_valid) state_n = (in_eom || b == ACW'(OB)) ? SEND : ACCUM;
      end
      ACCUM: begin
        rdy = compat;
        merge = umi_in_valid & compat;
        if (merge) state_n = (in_eom || nacc == ACW'(OB)) ? SEND : ACCUM;
        else if (umi_in_valid) state_n = SEND;
`ifdef UMI_MERGE_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) state_n = SEND;
`endif
      end
      SEND: if (umi_out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      acc <= '0;
      cmd <= '0;
      dst <= '0;
      src <= '0;
      data <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        cmd <= umi_in_cmd;
        dst <= umi_in_dstaddr;
        src <= umi_in_srcaddr;
        data <= ODW'(din);
        acc <= b;
      end else if (merge) begin
        cmd <= cmd_m;
        data <= data_m;
        acc <= nacc;
      end
    end
  end
`ifdef UMI_MERGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) tcnt <= '0;
    else if (load || merge) tcnt <= '0;
    else if (state == ACCUM && !umi_in_valid) tcnt <= tcnt + TW'(1);
  end
`endif
  assign umi_in_ready = nreset & rdy;
  assign umi_out_valid = (state == SEND);
  assign umi_out_cmd = cmd;
  assign umi_out_dstaddr = dst;
  assign umi_out_srcaddr = src;
  assign umi_out_data = data;
endmodule

// File: tb/tb_umi_merge.sv
// tb_umi_merge: directed and randomized checks of umi_merge against a byte-array reference model.
module tb_umi_merge;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] in_cmd = '0;
  logic [63:0] in_dst = '0, in_src = '0;
  logic [127:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic [31:0] out_cmd;
  logic [63:0] out_dst, out_src;
  logic [511:0] out_data;
  logic out_ready = 1'b0;
  int n_cmp = 0, n_err = 0;
  byte unsigned mb[64];
  int m_acc, m_size;
  bit m_eom;
  logic [31:0] m_cmd;
  logic [63:0] m_dst, m_src;

  always #5 clk = ~clk;

  umi_merge dut (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(in_valid), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(in_ready),
    .umi_out_valid(out_valid), .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst),
    .umi_out_srcaddr(out_src), .umi_out_data(out_data), .umi_out_ready(out_ready)
  );

  function automatic logic [31:0] mk_cmd(int op, int size, int len, bit eom, int host);
    return 32'(op & 31) | (32'(size & 7) << 5) | (32'(len & 255) << 8) |
           (32'(eom) << 22) | (32'(host & 31) << 27);
  endfunction

  function automatic void m_clear();
    foreach (mb[i]) mb[i] = 8'h00;
    m_acc = 0;
  endfunction

  function automatic void m_add(logic [31:0] c, logic [63:0] d, logic [63:0] s, logic [127:0] dat);
    int sz = int'(c[7:5]);
    int nb = (int'(c[15:8]) + 1) << sz;
    if (m_acc == 0) begin
      m_dst = d;
      m_src = s;
      m_size = sz;
      m_cmd = c;
    end
    for (int i = 0; i < nb; i++) mb[m_acc + i] = dat[8*i +: 8];
    m_acc += nb;
    m_eom = c[22];
  endfunction

  function automatic logic [31:0] m_exp_cmd();
    return mk_cmd(int'(m_cmd[4:0]), m_size, (m_acc >> m_size) - 1, m_eom, int'(m_cmd[31:27])) |
           (m_cmd & 32'h0003_0000);
  endfunction

  function automatic logic [511:0] m_exp_data();
    logic [511:0] r = '0;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = mb[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s,
                       input logic [127:0] dat);
    in_valid = 1'b1;
    in_cmd = c;
    in_dst = d;
    in_src = s;
    in_data = dat;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 0, 1);
  endtask

  task automatic check_out(input string tag);
    for (int k = 0; k < 40 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_cmd"}, out_cmd, m_exp_cmd());
    chk({tag, "_dst"}, out_dst, m_dst);
    chk({tag, "_src"}, out_src, m_src);
    chk({tag, "_data"}, out_data, m_exp_data());
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, out_valid, 0);
    m_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    logic [63:0] base;
    logic [127:0] dat;
    int host, op, sz, acc, len, nb;
    bit eom, seen;
    m_clear();
    m_eom = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cmd", out_cmd, 0);
    chk("rst_out_dst", out_dst, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);
    // four 16-byte segments into one full line
    host = $urandom_range(0, 31);
    for (int i = 0; i < 4; i++) begin
      c = mk_cmd(1, 0, 15, i == 3, host);
      dat = {$urandom, $urandom, $urandom, $urandom};
      drive(c, 64'h100 + 64'(16 * i), 64'h2000 + 64'(16 * i), dat);
      m_add(c, 64'h100 + 64'(16 * i), 64'h2000 + 64'(16 * i), dat);
      if (i < 3) chk("m4_no_early_out", out_valid, 0);
    end
    chk("m4_latency", out_valid, 1);
    chk("m4_len", out_cmd[15:8], 63);
    chk("m4_eom", out_cmd[22], 1);
    check_out("m4");
    // single short beat with eom
    c = mk_cmd(2, 0, 7, 1, 3);
    dat = {$urandom, $urandom, $urandom, $urandom};
    drive(c, 64'h40, 64'h80, dat);
    m_add(c, 64'h40, 64'h80, dat);
    chk("s1_latency", out_valid, 1);
    chk("s1_upper_zero", out_data[511:64], 0);
    check_out("s1");
    // incompatible address forces a flush of the partial line
    c = mk_cmd(1, 0, 15, 0, 5);
    dat = {$urandom, $urandom, $urandom, $urandom};
    drive(c, 64'h100, 64'h300, dat);
    m_add(c, 64'h100, 64'h300, dat);
    in_valid = 1'b1;
    in_cmd = mk_cmd(1, 0, 15, 1, 5);
    in_dst = 64'h200;
    in_src = 64'h400;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("inc_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    chk("inc_send_valid", out_valid, 1);
    chk("inc_send_ready_low", in_ready, 0);
    chk("inc_len", out_cmd[15:8], 15);
    check_out("inc_flush");
    chk("inc_idle_ready", in_ready, 1);
    m_add(in_cmd, in_dst, in_src, in_data);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("inc_second");
    // back-pressure on the output while another beat is offered
    c = mk_cmd(4, 0, 3, 1, 9);
    dat = {$urandom, $urandom, $urandom, $urandom};
    drive(c, 64'h800, 64'h900, dat);
    m_add(c, 64'h800, 64'h900, dat);
    in_valid = 1'b1;
    in_cmd = mk_cmd(4, 0, 3, 1, 9);
    in_dst = 64'h804;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_cmd", out_cmd, m_exp_cmd());
      chk("bp_data", out_data, m_exp_data());
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_out("bp");
    // idle timeout behaviour
    c = mk_cmd(1, 0, 15, 0, 7);
    dat = {$urandom, $urandom, $urandom, $urandom};
    drive(c, 64'h300, 64'h600, dat);
    m_add(c, 64'h300, 64'h600, dat);
`ifdef UMI_MERGE_TIMEOUT_EN
    acc = 1;
    while (!out_valid && acc < 40) begin
      @(posedge clk);
      #1;
      acc++;
    end
    chk("to_latency", acc, 17);
    check_out("to");
`else
    repeat (30) @(posedge clk);
    #1;
    chk("no_to_valid", out_valid, 0);
    nreset = 1'b0;
    #1;
    nreset = 1'b1;
    m_clear();
`endif
    // reset in the middle of an accumulation
    for (int i = 0; i < 2; i++) begin
      c = mk_cmd(1, 0, 15, 0, 2);
      drive(c, 64'h500 + 64'(16 * i), 64'h700 + 64'(16 * i), {$urandom, $urandom, $urandom, $urandom});
    end
    chk("rst_acc_valid_pre", out_valid, 0);
    #2;
    nreset = 1'b0;
    #1;
    chk("rst_acc_valid", out_valid, 0);
    chk("rst_acc_ready", in_ready, 0);
    chk("rst_acc_cmd", out_cmd, 0);
    chk("rst_acc_data", out_data, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    chk("rst_acc_no_out", seen, 0);
    // reset while an output is pending
    drive(mk_cmd(1, 0, 3, 1, 2), 64'h40, 64'h40, {$urandom, $urandom, $urandom, $urandom});
    chk("rst_send_pre", out_valid, 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("rst_send_valid", out_valid, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_send_after", out_valid, 0);
    m_clear();
    // random contiguous groups of mixed sizes
    for (int g = 0; g < 20; g++) begin
      sz = $urandom_range(0, 2);
      op = $urandom_range(0, 31);
      host = $urandom_range(0, 31);
      base = {32'($urandom), 32'($urandom)} & ~64'h3f;
      acc = 0;
      eom = 0;
      while (!eom && acc < 64) begin
        nb = ((64 - acc) < 16) ? (64 - acc) : 16;
        len = $urandom_range(0, (nb >> sz) - 1);
        nb = (len + 1) << sz;
        eom = ($urandom_range(0, 3) == 0) || (acc + nb == 64 && $urandom_range(0, 1) == 1);
        c = mk_cmd(op, sz, len, eom, host) | (32'($urandom_range(0, 3)) << 16);
        if (acc > 0) c[17:16] = m_cmd[17:16];
        dat = {$urandom, $urandom, $urandom, $urandom};
        drive(c, base + 64'(acc), base + 64'h1_0000 + 64'(acc), dat);
        m_add(c, base + 64'(acc), base + 64'h1_0000 + 64'(acc), dat);
        acc += nb;
      end
      chk("rnd_latency", out_valid, 1);
      check_out("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
